// File: rtl/mul_add_result_history_pkg.sv
// rtl/mul_add_result_history_pkg.sv - shared widths and lane/ring helpers for the result history
package mul_add_result_history_pkg;

  localparam int ELEMENT_WIDTH = 32;
  localparam int NUM_EQUATIONS = 9;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

  // depth is a power of two, so the modulo reduces to a mask
  function automatic int unsigned ring_idx(input int unsigned ptr, input int unsigned age,
                                           input int unsigned depth);
    return (ptr + depth - 1 - age) & (depth - 1);
  endfunction

endpackage

// File: rtl/mul_add_result_history_ptr.sv
// rtl/mul_add_result_history_ptr.sv - write pointer, occupancy and age-to-index mapping
module result_history_ptr
  import mul_add_result_history_pkg::*;
#(
  parameter int depth = 4,
  localparam int age_width = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_enable,
  input  logic                 clear,
  input  logic [age_width-1:0] rd_age,
  output logic [age_width-1:0] wr_ptr,
  output logic [age_width-1:0] newest_idx,
  output logic [age_width-1:0] rd_idx,
  output logic [age_width:0]   count,
  output logic                 full
);

  localparam int cnt_w = age_width + 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (write_enable) begin
      wr_ptr <= wr_ptr + age_width'(1);
      if (!full) count <= count + cnt_w'(1);
    end
  end

  assign full       = (count == cnt_w'(depth));
  assign newest_idx = wr_ptr - age_width'(1);
  assign rd_idx     = age_width'(ring_idx(32'(wr_ptr), 32'(rd_age), depth));

endmodule

// File: rtl/mul_add_result_history.sv
// rtl/mul_add_result_history.sv - ring buffer of recent mul_add result vectors with masked writes
// Optional MUL_ADD_RESULT_HISTORY_BYPASS_EN: same-cycle reads observe the accepted write.
module mul_add_result_history
  import mul_add_result_history_pkg::*;
#(
  parameter int number_of_equations_per_cluster = NUM_EQUATIONS,
  parameter int element_width = ELEMENT_WIDTH,
  parameter int depth = 4,
  localparam int age_width = $clog2(depth)
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [element_width*number_of_equations_per_cluster-1:0] input_data,
  input  logic                                               write_enable,
  input  logic [number_of_equations_per_cluster-1:0]         lane_mask,
  input  logic                                               clear,
  input  logic                                               rd_en,
  input  logic [age_width-1:0]                               rd_age,
  output logic [element_width*number_of_equations_per_cluster-1:0] memory_output,
  output logic [element_width*number_of_equations_per_cluster-1:0] rd_data,
  output logic                                               rd_valid,
  output logic                                               rd_err,
  output logic [age_width:0]                                 count,
  output logic                                               full
);

  localparam int vw = element_width * number_of_equations_per_cluster;

  logic [vw-1:0]        mem [depth];
  logic [vw-1:0]        newest;
  logic [vw-1:0]        merged;
  logic [vw-1:0]        rd_word;
  logic                 rd_miss;
  logic                 wr_accept;
  logic [age_width-1:0] wr_ptr;
  logic [age_width-1:0] newest_idx;
  logic [age_width-1:0] rd_idx;

  assign wr_accept = write_enable && !clear;

  result_history_ptr #(.depth(depth)) u_ptr (
    .clk          (clk),
    .rst          (rst),
    .write_enable (write_enable),
    .clear        (clear),
    .rd_age       (rd_age),
    .wr_ptr       (wr_ptr),
    .newest_idx   (newest_idx),
    .rd_idx       (rd_idx),
    .count        (count),
    .full         (full)
  );

  assign newest        = (count == '0) ? '0 : mem[newest_idx];
  assign memory_output = newest;

  always_comb begin
    merged = '0;
    for (int i = 0; i < number_of_equations_per_cluster; i++) begin
      merged[lane_lsb(i, element_width) +: element_width] = lane_mask[i]
          ? input_data[lane_lsb(i, element_width) +: element_width]
          : newest[lane_lsb(i, element_width) +: element_width];
    end
  end

`ifdef MUL_ADD_RESULT_HISTORY_BYPASS_EN
  logic [age_width:0] post_count;

  // After an accepted write every stored entry ages by one, so old age a-1 sits at rd_idx+1
  assign post_count = (wr_accept && !full) ? count + (age_width + 1)'(1) : count;
  assign rd_miss    = {1'b0, rd_age} >= post_count;
  assign rd_word    = !wr_accept        ? mem[rd_idx] :
                      (rd_age == '0)    ? merged :
                                          mem[rd_idx + age_width'(1)];
`else
  assign rd_miss = {1'b0, rd_age} >= count;
  assign rd_word = mem[rd_idx];
`endif

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_err  <= rd_miss;
        rd_data <= rd_miss ? '0 : rd_word;
      end
    end
  end

endmodule

// File: tb/tb_mul_add_result_history.sv
// tb/tb_mul_add_result_history.sv - directed self-checking bench for mul_add_result_history
module tb_mul_add_result_history;

  localparam int W  = 32;
  localparam int N  = 9;
  localparam int VW = W * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [VW-1:0] input_data = '0;
  logic          write_enable = 1'b0;
  logic [N-1:0]  lane_mask = '0;
  logic          clear = 1'b0;
  logic          rd_en = 1'b0;
  logic [1:0]    rd_age = '0;
  logic [VW-1:0] memory_output;
  logic [VW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_err;
  logic [2:0]    count;
  logic          full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_add_result_history dut (
    .clk           (clk),
    .rst           (rst),
    .input_data    (input_data),
    .write_enable  (write_enable),
    .lane_mask     (lane_mask),
    .clear         (clear),
    .rd_en         (rd_en),
    .rd_age        (rd_age),
    .memory_output (memory_output),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_err        (rd_err),
    .count         (count),
    .full          (full)
  );

  task automatic check_eq(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] vec(input int k);
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = 32'(256 * k + i);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic we, input logic clr, input logic re, input logic [1:0] age,
                       input logic [VW-1:0] data, input logic [N-1:0] mask);
    write_enable = we; clear = clr; rd_en = re; rd_age = age;
    input_data = data; lane_mask = mask;
    step();
    write_enable = 1'b0; clear = 1'b0; rd_en = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic err, input logic [VW-1:0] data);
    check_eq({tag, "_valid"}, VW'(rd_valid), VW'(1'b1));
    check_eq({tag, "_err"}, VW'(rd_err), VW'(err));
    check_eq({tag, "_data"}, rd_data, data);
  endtask

  logic [VW-1:0] m12;
  logic [VW-1:0] m5;

  initial begin
    m12 = vec(1);
    m12[0*W +: W] = vec(2) >> (0*W);
    m12[2*W +: W] = 32'(vec(2) >> (2*W));
    m5 = '0;
    m5[0 +: W] = 32'(256 * 5);

    step(); step();
    check_eq("rst_count", VW'(count), '0);
    check_eq("rst_full", VW'(full), '0);
    check_eq("rst_valid", VW'(rd_valid), '0);
    check_eq("rst_mem_out", memory_output, '0);
    rst = 1'b0;
    step();

    // read from empty history
    cycle(0, 0, 1, 2'd0, '0, '0);
    check_read("empty_rd", 1'b1, '0);
    check_eq("empty_count", VW'(count), '0);
    step();
    check_eq("idle_valid", VW'(rd_valid), '0);

    // three full-mask writes then back-to-back reads
    for (int k = 1; k <= 3; k++) cycle(1, 0, 0, 2'd0, vec(k), '1);
    check_eq("w3_count", VW'(count), 3);
    check_eq("w3_mem_out", memory_output, vec(3));
    rd_en = 1'b1; rd_age = 2'd0; step();
    check_read("b2b_age0", 1'b0, vec(3));
    rd_age = 2'd1; step();
    check_read("b2b_age1", 1'b0, vec(2));
    rd_age = 2'd2; step();
    check_read("b2b_age2", 1'b0, vec(1));
    rd_en = 1'b0; step();
    check_eq("hold_valid", VW'(rd_valid), '0);
    check_eq("hold_data", rd_data, vec(1));
    cycle(0, 0, 1, 2'd3, '0, '0);
    check_read("w3_age3", 1'b1, '0);

    // wrap past depth
    for (int k = 4; k <= 6; k++) cycle(1, 0, 0, 2'd0, vec(k), '1);
    check_eq("w6_count", VW'(count), 4);
    check_eq("w6_full", VW'(full), 1);
    cycle(0, 0, 1, 2'd3, '0, '0);
    check_read("w6_age3", 1'b0, vec(3));
    cycle(0, 0, 1, 2'd0, '0, '0);
    check_read("w6_age0", 1'b0, vec(6));

    // masked merge
    cycle(0, 1, 0, 2'd0, '0, '0);
    check_eq("clr_count", VW'(count), '0);
    cycle(1, 0, 0, 2'd0, vec(1), '1);
    cycle(1, 0, 0, 2'd0, vec(2), 9'b000000101);
    check_eq("merge_mem_out", memory_output, m12);

    // clear with write and read in the same cycle
    cycle(1, 1, 1, 2'd0, vec(7), '1);
    check_read("clr_rd", 1'b0, m12);
    check_eq("clrw_count", VW'(count), '0);
    check_eq("clrw_mem_out", memory_output, '0);
    cycle(0, 0, 1, 2'd0, '0, '0);
    check_read("clrw_dropped", 1'b1, '0);

    // same-cycle write and read
    cycle(1, 0, 1, 2'd0, vec(1), '1);
`ifdef MUL_ADD_RESULT_HISTORY_BYPASS_EN
    check_read("wr_rd_a0_empty", 1'b0, vec(1));
`else
    check_read("wr_rd_a0_empty", 1'b1, '0);
`endif
    cycle(1, 0, 1, 2'd1, vec(2), '1);
`ifdef MUL_ADD_RESULT_HISTORY_BYPASS_EN
    check_read("wr_rd_a1", 1'b0, vec(1));
`else
    check_read("wr_rd_a1", 1'b1, '0);
`endif
    cycle(1, 0, 1, 2'd0, vec(3), '1);
`ifdef MUL_ADD_RESULT_HISTORY_BYPASS_EN
    check_read("wr_rd_a0", 1'b0, vec(3));
`else
    check_read("wr_rd_a0", 1'b0, vec(2));
`endif

    // async reset during a read
    cycle(1, 0, 0, 2'd0, vec(4), '1);
    check_eq("pre_rst_full", VW'(full), 1);
    cycle(0, 0, 1, 2'd0, '0, '0);
    check_eq("pre_rst_valid", VW'(rd_valid), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", VW'(rd_valid), '0);
    check_eq("arst_count", VW'(count), '0);
    check_eq("arst_full", VW'(full), '0);
    check_eq("arst_mem_out", memory_output, '0);
    step();
    rst = 1'b0;

    // merge against an empty history takes zeros for masked-off lanes
    cycle(1, 0, 0, 2'd0, vec(5), 9'h001);
    check_eq("empty_merge", memory_output, m5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_add_result_history.md
Name: mul_add_result_history

Overview:
- Parametrised successor to the single-entry previous-result register used by the mul_add stage.
- Ring buffer holding the last `depth` result vectors of `number_of_equations_per_cluster` elements each.
- Writes support a per-lane mask; unmasked lanes are carried over from the newest entry.
- Provides a combinational "latest" output plus a registered read-by-age port, so iterative solver stages can fetch result(k-n).

Parameters:
- number_of_equations_per_cluster, 9, lanes per vector.
- element_width, 32, bits per lane.
- depth, 4, stored vectors; power of two, at least 2.
- age_width, $clog2(depth), derived; not to be overridden.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- input_data  in  element_width*number_of_equations_per_cluster  vector to write; lane i = bits [i*element_width +: element_width].
- write_enable  in  1  push a new entry this cycle.
- lane_mask  in  number_of_equations_per_cluster  1 = take lane from input_data, 0 = copy lane from current newest entry.
- clear  in  1  synchronous flush of history.
- rd_en  in  1  read request.
- rd_age  in  age_width  0 = newest, depth-1 = oldest.
- memory_output  out  element_width*number_of_equations_per_cluster  newest entry, combinational from storage; all zeros when count==0.
- rd_data  out  element_width*number_of_equations_per_cluster  registered read data.
- rd_valid  out  1  pulses one cycle after rd_en.
- rd_err  out  1  with rd_valid: rd_age >= count.
- count  out  age_width+1  valid entries, 0..depth.
- full  out  1  count==depth.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, count=0, rd_valid=0, rd_err=0, rd_data=0. memory_output reads 0 because count==0. Storage array itself is not reset.
- Write, when write_enable=1 and clear=0:
  - mem[wr_ptr] <= merged vector.
  - wr_ptr <= wr_ptr+1 (mod depth).
  - count <= min(count+1, depth).
- Merge rule: lane i = lane_mask[i] ? input_data lane i : newest lane i. When count==0 the "newest" source is zero.
- Full: a write overwrites the oldest entry and count stays at depth. There is no back-pressure.
- Address mapping: newest = wr_ptr-1; age a maps to (wr_ptr-1-a) mod depth.
- Read, rd_en=1 at edge n: at cycle n+1, rd_valid=1 and rd_data = entry at age rd_age, sampled from pre-edge state.
  - If rd_age >= count: rd_data=0, rd_err=1.
  - Otherwise rd_err=0.
  - Latency is 1 cycle; one read per cycle is sustained.
- rd_en=0: rd_valid=0 next cycle; rd_data holds its last value.
- clear=1: wr_ptr<=0, count<=0. Clear has priority, so a simultaneous write is dropped. A read issued in the same cycle still returns pre-clear contents.
- memory_output updates on the cycle after a write edge.
- Reset mid-read: rd_valid forced to 0 immediately.

Optional Feature:
- Macro: MUL_ADD_RESULT_HISTORY_BYPASS_EN.
- Defined: a read in the same cycle as an accepted write returns post-write ages.
  - Age 0 returns the merged input vector.
  - Age a>0 returns the old age a-1.
  - rd_err is evaluated against the post-write count.
- Undefined: reads always see pre-edge state, as specified above.

Decomposition:
- Shared package/header holds:
  - Lane-slice macro/function.
  - Default widths ELEMENT_WIDTH=32 and NUM_EQUATIONS=9.
  - Ring-address helper (age -> index).
- One natural sub-module, result_history_ptr: owns wr_ptr and count, and produces newest_idx, the age-to-index mapping, and full.
- Storage, merge and read register remain in the top module.

Test Plan:
- Reset then read age 0 -> rd_valid=1 one cycle later, rd_err=1, rd_data=0, memory_output=0, count=0.
- Write V1..V3 with lanes i = 0x100*k+i (full mask), then read ages 0,1,2 back-to-back -> V3, V2, V1 on consecutive cycles; rd_err=0; count=3.
- Write 6 vectors at depth 4 -> count=4, full=1; age 3 returns V3 (V1 and V2 overwritten); age 0 returns V6.
- Write V1 full mask, then V2 with lane_mask=9'b000000101 -> memory_output lanes 0 and 2 from V2, all other lanes from V1.
- Assert clear together with write_enable -> count=0, memory_output=0; the dropped write's data is never visible; a same-cycle read returns the pre-clear value.
- Write and read age 0 in the same cycle -> returns the previous newest; with MUL_ADD_RESULT_HISTORY_BYPASS_EN defined, returns the merged input.
- Assert rst asynchronously between edges during a read -> rd_valid, count and full drop to 0 immediately.
